four_bit_rca_rcs: RTL and testbench



---
 rtl/four_bit_rca_rcs_if.sv | 33 +++
 rtl/four_bit_rca_rcs.sv | 76 +++++++
 tb/tb_four_bit_rca_rcs.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/four_bit_rca_rcs_if.sv
// rtl/four_bit_rca_rcs_if.sv - operand/result bundle for the registered 4-bit add/subtract unit
//
// Purpose: groups the operand request and registered result signals.
// Signals:
//   in_valid  operands valid this cycle (master -> slave)
//   sub       0 = add, 1 = subtract (master -> slave)
//   A, B      4-bit operands (master -> slave)
//   Cin       carry-in to bit 0 (master -> slave)
//   S         registered sum/difference (slave -> master)
//   Cout      registered carry out of bit 3 (slave -> master)
//   V         registered signed-overflow flag (slave -> master)
//   out_valid result registers updated by the previous cycle's in_valid (slave -> master)
interface four_bit_rca_rcs_if;
    logic       in_valid;
    logic       sub;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] S;
    logic       Cout;
    logic       V;
    logic       out_valid;

    modport master (
        output in_valid, sub, A, B, Cin,
        input  S, Cout, V, out_valid
    );

    modport slave (
        input  in_valid, sub, A, B, Cin,
        output S, Cout, V, out_valid
    );
endinterface

// File: rtl/four_bit_rca_rcs.sv
// rtl/four_bit_rca_rcs.sv - registered 4-bit ripple-carry add/subtract unit
//
// Purpose: four chained full adders compute A + (sub ? ~B : B) + Cin; the
// sum, carry-out and signed-overflow flag are captured in output registers
// for a one-cycle-latency interface.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset (priority over in_valid)
//   bus  four_bit_rca_rcs_if.slave: in_valid/sub/A/B/Cin in, S/Cout/V/out_valid out
module four_bit_rca_rcs (
    input  logic                 clk,
    input  logic                 rst,
    four_bit_rca_rcs_if.slave    bus
);

    // Ripple chain of four full-adder cells. Returns {c3, c4, s[3:0]}; c3 is
    // exposed because the overflow flag is the XOR of the last two carries.
    function automatic logic [5:0] rca4(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       cin
    );
        logic [4:0] c;
        logic [3:0] s;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        return {c[3], c[4], s};
    endfunction

    logic [3:0] b_op;
    logic [5:0] chain;

    logic [3:0] s_d,         s_q;
    logic       cout_d,      cout_q;
    logic       v_d,         v_q;
    logic       out_valid_d, out_valid_q;

    always_comb begin
        // Subtraction inverts B only; Cin is taken exactly as the caller drives it.
        b_op  = bus.B ^ {4{bus.sub}};
        chain = rca4(bus.A, b_op, bus.Cin);

        s_d         = s_q;
        cout_d      = cout_q;
        v_d         = v_q;
        out_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            s_d    = chain[3:0];
            cout_d = chain[4];
            v_d    = chain[5] ^ chain[4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= 4'b0000;
            cout_q      <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            cout_q      <= cout_d;
            v_q         <= v_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.V         = v_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_four_bit_rca_rcs.sv
// tb/tb_four_bit_rca_rcs.sv - scoreboard testbench for the registered 4-bit add/subtract unit
module tb_four_bit_rca_rcs;

    typedef struct packed {
        logic [3:0] s;
        logic       c;
        logic       v;
    } exp_t;

    logic clk;
    logic rst;
    four_bit_rca_rcs_if bus();

    four_bit_rca_rcs dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t held;
    bit   rst_seen = 1'b1;
    bit   started  = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for S/Cout, signed range for V.
    function automatic exp_t model(input logic sub, input logic [3:0] a,
                                   input logic [3:0] b, input logic cin);
        int   bo, u, sa, sb, sr;
        exp_t e;
        bo  = sub ? (15 - int'(b)) : int'(b);
        u   = int'(a) + bo + int'(cin);
        sa  = (int'(a) >= 8) ? int'(a) - 16 : int'(a);
        sb  = (bo >= 8) ? bo - 16 : bo;
        sr  = sa + sb + int'(cin);
        e.s = 4'(u % 16);
        e.c = (u >= 16);
        e.v = (sr > 7) || (sr < -8);
        return e;
    endfunction

    // Capture: record what the DUT samples at each edge.
    always @(posedge clk) begin
        started  = 1'b1;
        rst_seen = rst;
        if (!rst && bus.in_valid)
            exp_q.push_back(model(bus.sub, bus.A, bus.B, bus.Cin));
    end

    // Monitor: compare on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (rst_seen) begin
                check("rst_S", 8'(bus.S), 8'd0);
                check("rst_Cout", 8'(bus.Cout), 8'd0);
                check("rst_V", 8'(bus.V), 8'd0);
                check("rst_out_valid", 8'(bus.out_valid), 8'd0);
                exp_q.delete();
                held = '0;
            end else begin
                check("out_valid", 8'(bus.out_valid), 8'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("S", 8'(bus.S), 8'(e.s));
                    check("Cout", 8'(bus.Cout), 8'(e.c));
                    check("V", 8'(bus.V), 8'(e.v));
                    held = e;
                end else begin
                    check("hold_S", 8'(bus.S), 8'(held.s));
                    check("hold_Cout", 8'(bus.Cout), 8'(held.c));
                    check("hold_V", 8'(bus.V), 8'(held.v));
                end
            end
        end
    end

    // Drive from a point #1 after an edge, then advance to #1 after the next edge.
    task automatic drive(input logic r, input logic iv, input logic sub,
                         input logic [3:0] a, input logic [3:0] b, input logic cin);
        rst          = r;
        bus.in_valid = iv;
        bus.sub      = sub;
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string name, input logic sub, input logic [3:0] a,
                            input logic [3:0] b, input logic cin,
                            input logic [3:0] es, input logic ec, input logic ev);
        drive(1'b0, 1'b1, sub, a, b, cin);
        check({name, "_S"}, 8'(bus.S), 8'(es));
        check({name, "_Cout"}, 8'(bus.Cout), 8'(ec));
        check({name, "_V"}, 8'(bus.V), 8'(ev));
        check({name, "_out_valid"}, 8'(bus.out_valid), 8'd1);
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.sub      = 1'b0;
        bus.A        = 4'd0;
        bus.B        = 4'd0;
        bus.Cin      = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

        directed("add_u", 1'b0, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b1 ^ 1'b1, 1'b1);
        directed("add_s", 1'b0, 4'b1111, 4'b1110, 1'b0, 4'b1101, 1'b1, 1'b0);
        directed("sub_u", 1'b1, 4'b0111, 4'b0011, 1'b1, 4'b0100, 1'b1, 1'b0);
        directed("sub_s", 1'b1, 4'b1001, 4'b1010, 1'b1, 4'b1111, 1'b0, 1'b0);

        // Hold: new operands without in_valid leave the previous result.
        drive(1'b0, 1'b0, 1'b0, 4'b0101, 4'b0101, 1'b1);
        check("hold_dir_S", 8'(bus.S), 8'b1111);
        check("hold_dir_Cout", 8'(bus.Cout), 8'd0);
        check("hold_dir_out_valid", 8'(bus.out_valid), 8'd0);

        // Reset wins over a simultaneous valid.
        drive(1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111, 1'b1);
        check("rst_prio_S", 8'(bus.S), 8'd0);
        check("rst_prio_Cout", 8'(bus.Cout), 8'd0);
        check("rst_prio_V", 8'(bus.V), 8'd0);
        check("rst_prio_out_valid", 8'(bus.out_valid), 8'd0);

        // Exhaustive, back-to-back.
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    for (int c = 0; c < 2; c++)
                        drive(1'b0, 1'b1, 1'(s), 4'(a), 4'(b), 1'(c));

        // Random mix of valids, idles and occasional resets.
        for (int i = 0; i < 2000; i++)
            drive(($urandom_range(0, 99) < 3), ($urandom_range(0, 3) != 0),
                  1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));

        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        #1;
        check("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
